multiplexor_pipe_param: RTL



---
 rtl/mips_mux_pkg.sv | 19 +
 rtl/multiplexor_n_comb.sv | 28 ++
 rtl/multiplexor_pipe_param.sv | 81 ++++++++
 3 files changed

// File: rtl/mips_mux_pkg.sv
// Shared definitions for the pipelined N:1 operand multiplexor.
package mips_mux_pkg;

    localparam int MAX_INPUTS = 16;
    localparam int MAX_STAGES = 4;

    // Selector width for n inputs; a 1-input or 2-input mux still needs one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Control half of a pipeline stage record. The data field depends on
    // LENGTH, so the full record is built from this inside the top level.
    typedef struct packed {
        logic valid;
        logic err;
    } stage_ctl_t;

endpackage

// File: rtl/multiplexor_n_comb.sv
// Combinational N:1 select with out-of-range selector detection.
module multiplexor_n_comb
    import mips_mux_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int INPUTS = 4
) (
    input  logic [INPUTS*LENGTH-1:0]     i_data,
    input  logic [sel_width(INPUTS)-1:0] i_selector,
    output logic [LENGTH-1:0]            data,
    output logic                         err
);

    localparam int SEL_W = sel_width(INPUTS);

    // Forward the addressed input; an unmatched selector yields zeros plus err.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int k = 0; k < INPUTS; k++) begin
            if (i_selector == SEL_W'(k)) begin
                data = i_data[k*LENGTH +: LENGTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multiplexor_pipe_param.sv
// N:1 multiplexor followed by a STAGES-deep register pipeline with stall,
// flush, valid tracking and a saturating out-of-range selector counter.
module multiplexor_pipe_param
    import mips_mux_pkg::*;
#(
    parameter int LENGTH    = 32,
    parameter int INPUTS    = 4,
    parameter int STAGES    = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*LENGTH-1:0]     i_data,
    input  logic [sel_width(INPUTS)-1:0] i_selector,
    input  logic                         i_valid,
    input  logic                         i_stall,
    input  logic                         i_flush,
    output logic [LENGTH-1:0]            out,
    output logic                         o_valid,
    output logic                         o_sel_err,
    output logic [ERR_CNT_W-1:0]         o_err_count
);

    localparam int SEL_W = sel_width(INPUTS);

    generate
        if (INPUTS < 2 || INPUTS > MAX_INPUTS || STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_param
            $error("multiplexor_pipe_param: INPUTS must be 2..16 and STAGES 1..4");
        end
    endgenerate

    typedef struct packed {
        logic [LENGTH-1:0] data;
        stage_ctl_t        ctl;
    } stage_t;

    logic [LENGTH-1:0]    sel_data;
    logic                 sel_err;
    stage_t               stg [STAGES];
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 advance;

    multiplexor_n_comb #(
        .LENGTH (LENGTH),
        .INPUTS (INPUTS)
    ) u_sel (
        .i_data     (i_data),
        .i_selector (i_selector),
        .data       (sel_data),
        .err        (sel_err)
    );

    assign advance = !i_flush && !i_stall;

    // Stage chain: reset and flush clear everything, stall holds, else shift.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int k = 0; k < STAGES; k++) stg[k] <= '0;
        end else if (!i_stall) begin
            stg[0].data      <= sel_data;
            stg[0].ctl.valid <= i_valid;
            stg[0].ctl.err   <= i_valid && sel_err;
            for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
        end
    end

    // Count accepted out-of-range selections; sticks at all-ones, only rst clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (advance && i_valid && sel_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign out         = stg[STAGES-1].data;
    assign o_valid     = stg[STAGES-1].ctl.valid;
    assign o_sel_err   = stg[STAGES-1].ctl.err;
    assign o_err_count = err_cnt;

endmodule
